// File: rtl/sqrt_pkg.sv
// Shared constants for the round-robin square-root scheduler.
// Holds the FSM state encoding and the default build parameters.
package sqrt_pkg;

  // Default build parameters
  localparam int unsigned SQRT_N_REQ       = 4;
  localparam int unsigned SQRT_WIDTH       = 8;
  localparam int unsigned SQRT_TIMEOUT_CYC = 64;
  localparam int unsigned SQRT_CNT_W       = 8;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

endpackage

// File: rtl/sqrt_rr_arbiter.sv
// Combinational rotate-priority arbiter.
// Ports:
//   i_valid  - per-requester request valid
//   i_ptr    - highest-priority requester index for this round
//   o_grant  - one-hot grant (zero when nothing is valid)
//   o_id     - encoded index of the granted requester (zero when none)
module sqrt_rr_arbiter
  import sqrt_pkg::*;
#(
  parameter int unsigned N_REQ = SQRT_N_REQ,
  parameter int unsigned ID_W  = $clog2(SQRT_N_REQ)
) (
  input  logic [N_REQ-1:0] i_valid,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [ID_W-1:0]  o_id
);

  int unsigned     w_idx;
  logic [ID_W-1:0] w_idx_b;
  logic            w_found;

  // Walk from i_ptr upward with wrap; first valid requester wins
  always_comb begin
    o_grant = '0;
    o_id    = '0;
    w_found = 1'b0;
    w_idx   = 0;
    w_idx_b = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_idx = int'(i_ptr) + k;
      if (w_idx >= N_REQ) begin
        w_idx = w_idx - N_REQ;
      end
      w_idx_b = ID_W'(w_idx);
      if (!w_found && i_valid[w_idx_b]) begin
        w_found          = 1'b1;
        o_grant[w_idx_b] = 1'b1;
        o_id             = w_idx_b;
      end
    end
  end

endmodule

// File: rtl/sqrt_arbiter.sv
// Round-robin scheduler sharing one sequential square-root core among
// N_REQ requesters. One job in flight: accept, launch, wait for done or
// watchdog, then hold the response until the consumer takes it.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   req_valid_i     - per-requester request valid
//   req_operand_i   - packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_ready_o     - one-hot accept (combinational, IDLE only)
//   rsp_valid_o     - response valid, held until rsp_ready_i
//   rsp_ready_i     - response consumer ready
//   rsp_root_o      - core result, 0 on timeout
//   rsp_id_o        - index of the served requester
//   rsp_timeout_o   - watchdog fired
//   rsp_cycles_o    - WAIT cycles spent
//   core_start_o    - one-cycle launch pulse
//   core_operand_o  - operand to the core, held from START through WAIT
//   core_done_i     - core result valid (sampled in WAIT only)
//   core_root_i     - core result
module sqrt_arbiter
  import sqrt_pkg::*;
#(
  parameter int unsigned N_REQ       = SQRT_N_REQ,
  parameter int unsigned WIDTH       = SQRT_WIDTH,
  parameter int unsigned TIMEOUT_CYC = SQRT_TIMEOUT_CYC,
  parameter int unsigned CNT_W       = SQRT_CNT_W,
  localparam int unsigned ID_W       = $clog2(N_REQ),
  localparam int unsigned ROOT_W     = WIDTH / 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid_i,
  input  logic [N_REQ*WIDTH-1:0] req_operand_i,
  output logic [N_REQ-1:0]       req_ready_o,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [ROOT_W-1:0]      rsp_root_o,
  output logic [ID_W-1:0]        rsp_id_o,
  output logic                   rsp_timeout_o,
  output logic [CNT_W-1:0]       rsp_cycles_o,
  output logic                   core_start_o,
  output logic [WIDTH-1:0]       core_operand_o,
  input  logic                   core_done_i,
  input  logic [ROOT_W-1:0]      core_root_i
);

  // Registered state
  logic [1:0]        r_state;
  logic              r_armed;
  logic [ID_W-1:0]   r_ptr;
  logic [ID_W-1:0]   r_id;
  logic [WIDTH-1:0]  r_operand;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_core_start;
  logic              r_rsp_valid;
  logic [ROOT_W-1:0] r_rsp_root;
  logic [ID_W-1:0]   r_rsp_id;
  logic              r_rsp_timeout;
  logic [CNT_W-1:0]  r_rsp_cycles;

  // Next-state values
  logic [1:0]        w_state_nxt;
  logic [ID_W-1:0]   w_ptr_nxt;
  logic [ID_W-1:0]   w_id_nxt;
  logic [WIDTH-1:0]  w_operand_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_core_start_nxt;
  logic              w_rsp_valid_nxt;
  logic [ROOT_W-1:0] w_rsp_root_nxt;
  logic [ID_W-1:0]   w_rsp_id_nxt;
  logic              w_rsp_timeout_nxt;
  logic [CNT_W-1:0]  w_rsp_cycles_nxt;

  logic [N_REQ-1:0]  w_grant;
  logic [ID_W-1:0]   w_grant_id;
  logic [WIDTH-1:0]  w_sel_operand;
  logic              w_accept;

  sqrt_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr (
    .i_valid (req_valid_i),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_id    (w_grant_id)
  );

  // r_armed keeps ready low until the first edge after reset release
  assign req_ready_o = (r_state == ST_IDLE && r_armed) ? w_grant : '0;
  assign w_accept    = |req_ready_o;

  // Operand mux driven by the one-hot grant
  always_comb begin
    w_sel_operand = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (w_grant[k]) begin
        w_sel_operand = req_operand_i[k*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    w_state_nxt       = r_state;
    w_ptr_nxt         = r_ptr;
    w_id_nxt          = r_id;
    w_operand_nxt     = r_operand;
    w_cnt_nxt         = r_cnt;
    w_core_start_nxt  = 1'b0;
    w_rsp_valid_nxt   = r_rsp_valid;
    w_rsp_root_nxt    = r_rsp_root;
    w_rsp_id_nxt      = r_rsp_id;
    w_rsp_timeout_nxt = r_rsp_timeout;
    w_rsp_cycles_nxt  = r_rsp_cycles;

    case (r_state)
      ST_IDLE: begin
        w_rsp_valid_nxt = 1'b0;
        if (w_accept) begin
          w_operand_nxt    = w_sel_operand;
          w_id_nxt         = w_grant_id;
          w_ptr_nxt        = (w_grant_id == ID_W'(N_REQ - 1)) ? '0
                                                               : w_grant_id + ID_W'(1);
          w_core_start_nxt = 1'b1;
          w_state_nxt      = ST_START;
        end
      end

      ST_START: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_WAIT;
      end

      ST_WAIT: begin
        w_cnt_nxt = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
        // done has priority over a simultaneous watchdog expiry
        if (core_done_i) begin
          w_rsp_valid_nxt   = 1'b1;
          w_rsp_root_nxt    = core_root_i;
          w_rsp_id_nxt      = r_id;
          w_rsp_timeout_nxt = 1'b0;
          w_rsp_cycles_nxt  = r_cnt;
          w_state_nxt       = ST_RESP;
        end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          w_rsp_valid_nxt   = 1'b1;
          w_rsp_root_nxt    = '0;
          w_rsp_id_nxt      = r_id;
          w_rsp_timeout_nxt = 1'b1;
          w_rsp_cycles_nxt  = CNT_W'(TIMEOUT_CYC);
          w_state_nxt       = ST_RESP;
        end
      end

      ST_RESP: begin
        w_rsp_valid_nxt = 1'b1;
        if (rsp_ready_i) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt       = ST_IDLE;
        w_cnt_nxt         = '0;
        w_rsp_valid_nxt   = 1'b0;
        w_rsp_root_nxt    = '0;
        w_rsp_id_nxt      = '0;
        w_rsp_timeout_nxt = 1'b0;
        w_rsp_cycles_nxt  = '0;
        w_operand_nxt     = '0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_armed       <= 1'b0;
      r_ptr         <= '0;
      r_id          <= '0;
      r_operand     <= '0;
      r_cnt         <= '0;
      r_core_start  <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_root    <= '0;
      r_rsp_id      <= '0;
      r_rsp_timeout <= 1'b0;
      r_rsp_cycles  <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_armed       <= 1'b1;
      r_ptr         <= w_ptr_nxt;
      r_id          <= w_id_nxt;
      r_operand     <= w_operand_nxt;
      r_cnt         <= w_cnt_nxt;
      r_core_start  <= w_core_start_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_root    <= w_rsp_root_nxt;
      r_rsp_id      <= w_rsp_id_nxt;
      r_rsp_timeout <= w_rsp_timeout_nxt;
      r_rsp_cycles  <= w_rsp_cycles_nxt;
    end
  end

  assign rsp_valid_o    = r_rsp_valid;
  assign rsp_root_o     = r_rsp_root;
  assign rsp_id_o       = r_rsp_id;
  assign rsp_timeout_o  = r_rsp_timeout;
  assign rsp_cycles_o   = r_rsp_cycles;
  assign core_start_o   = r_core_start;
  assign core_operand_o = r_operand;

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Directed bench for sqrt_arbiter; the bench itself plays the sqrt core.
module tb_sqrt_arbiter;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned TMO   = 64;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned ID_W  = 2;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [N_REQ-1:0]       req_valid_i;
  logic [N_REQ*WIDTH-1:0] req_operand_i;
  logic [N_REQ-1:0]       req_ready_o;
  logic                   rsp_valid_o;
  logic                   rsp_ready_i;
  logic [WIDTH/2-1:0]     rsp_root_o;
  logic [ID_W-1:0]        rsp_id_o;
  logic                   rsp_timeout_o;
  logic [CNT_W-1:0]       rsp_cycles_o;
  logic                   core_start_o;
  logic [WIDTH-1:0]       core_operand_o;
  logic                   core_done_i;
  logic [WIDTH/2-1:0]     core_root_i;

  int n_chk   = 0;
  int n_err   = 0;
  int n_start = 0;

  sqrt_arbiter #(
    .N_REQ       (N_REQ),
    .WIDTH       (WIDTH),
    .TIMEOUT_CYC (TMO),
    .CNT_W       (CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid_i    (req_valid_i),
    .req_operand_i  (req_operand_i),
    .req_ready_o    (req_ready_o),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_root_o     (rsp_root_o),
    .rsp_id_o       (rsp_id_o),
    .rsp_timeout_o  (rsp_timeout_o),
    .rsp_cycles_o   (rsp_cycles_o),
    .core_start_o   (core_start_o),
    .core_operand_o (core_operand_o),
    .core_done_i    (core_done_i),
    .core_root_i    (core_root_i)
  );

  always #5 clk = ~clk;

  // Count launch pulses away from the active edge
  always @(negedge clk) begin
    if (core_start_o) n_start++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"},   32'(req_ready_o),    0);
    chk({tag, "_valid"},   32'(rsp_valid_o),    0);
    chk({tag, "_root"},    32'(rsp_root_o),     0);
    chk({tag, "_id"},      32'(rsp_id_o),       0);
    chk({tag, "_tmo"},     32'(rsp_timeout_o),  0);
    chk({tag, "_cycles"},  32'(rsp_cycles_o),   0);
    chk({tag, "_start"},   32'(core_start_o),   0);
    chk({tag, "_operand"}, 32'(core_operand_o), 0);
  endtask

  // One complete job: accept, core answer after done_k WAIT cycles
  // (done_k < 0 means never), optional back-pressure and spurious done.
  task automatic job(input logic [3:0] mask, input int exp_id, input int exp_op,
                     input int done_k, input logic [3:0] root, input int hold,
                     input bit spur);
    int n;
    int s0;
    int exp_n;
    logic [3:0]       h_root;
    logic [ID_W-1:0]  h_id;
    logic             h_tmo;
    logic [CNT_W-1:0] h_cyc;
    req_valid_i = mask;
    rsp_ready_i = 1'b0;
    if (spur) begin
      core_done_i = 1'b1;
      core_root_i = 4'hA;
    end
    #1;
    chk("grant", 32'(req_ready_o), 32'(1 << exp_id));
    s0 = n_start;
    step();
    chk("start_pulse", 32'(core_start_o), 1);
    chk("core_op",     32'(core_operand_o), 32'(exp_op));
    chk("busy_ready",  32'(req_ready_o), 0);
    step();
    core_done_i = 1'b0;
    chk("start_low",   32'(core_start_o), 0);
    chk("op_hold",     32'(core_operand_o), 32'(exp_op));
    n = 0;
    while (rsp_valid_o !== 1'b1 && n < int'(TMO) + 20) begin
      core_done_i = (done_k >= 0 && n == done_k);
      core_root_i = root;
      step();
      n++;
    end
    core_done_i = 1'b0;
    exp_n = (done_k >= 0) ? done_k + 1 : int'(TMO);
    chk("latency",    32'(n), 32'(exp_n));
    chk("rsp_valid",  32'(rsp_valid_o), 1);
    chk("rsp_root",   32'(rsp_root_o), (done_k >= 0) ? 32'(root) : 0);
    chk("rsp_id",     32'(rsp_id_o), 32'(exp_id));
    chk("rsp_tmo",    32'(rsp_timeout_o), (done_k >= 0) ? 0 : 1);
    chk("rsp_cycles", 32'(rsp_cycles_o), (done_k >= 0) ? 32'(done_k) : 32'(TMO));
    h_root = rsp_root_o;
    h_id   = rsp_id_o;
    h_tmo  = rsp_timeout_o;
    h_cyc  = rsp_cycles_o;
    for (int h = 0; h < hold; h++) begin
      req_valid_i = 4'hF;
      if (spur) begin
        core_done_i = 1'b1;
        core_root_i = 4'h3;
      end
      step();
      chk("bp_valid",  32'(rsp_valid_o),   1);
      chk("bp_root",   32'(rsp_root_o),    32'(h_root));
      chk("bp_id",     32'(rsp_id_o),      32'(h_id));
      chk("bp_tmo",    32'(rsp_timeout_o), 32'(h_tmo));
      chk("bp_cycles", 32'(rsp_cycles_o),  32'(h_cyc));
      chk("bp_ready",  32'(req_ready_o),   0);
    end
    core_done_i = 1'b0;
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    chk("rsp_drop",  32'(rsp_valid_o), 0);
    chk("n_starts",  32'(n_start - s0), 1);
  endtask

  initial begin
    logic [7:0] ops [4];
    logic [3:0] roots [4];
    int         ord [5];
    ops   = '{8'd49, 8'd81, 8'd100, 8'd255};
    roots = '{4'd7, 4'd9, 4'd10, 4'd15};
    ord   = '{0, 1, 2, 3, 0};

    rst_n         = 1'b0;
    req_valid_i   = 4'hF;
    req_operand_i = {ops[3], ops[2], ops[1], ops[0]};
    rsp_ready_i   = 1'b0;
    core_done_i   = 1'b1;
    core_root_i   = 4'h5;

    // Reset state, with stray request and done present
    step();
    chk_all_zero("rst_a");
    step();
    chk_all_zero("rst_b");
    core_done_i = 1'b0;
    req_valid_i = 4'h1;
    rst_n       = 1'b1;
    #1;
    chk("post_rel_ready", 32'(req_ready_o), 0);
    step();

    // Single job with 10-cycle back-pressure
    job(4'h1, 0, 49, 6, 4'd7, 10, 1'b0);
    // Watchdog timeout, then a normal minimum-latency job
    job(4'h4, 2, 100, -1, 4'd0, 0, 1'b0);
    job(4'h8, 3, 255, 0, 4'd15, 0, 1'b0);
    // Fairness with all requesters valid
    for (int i = 0; i < 5; i++) begin
      job(4'hF, ord[i], int'(ops[ord[i]]), i + 1, roots[ord[i]], 0, 1'b0);
    end
    // Spurious done in IDLE/START/RESP
    job(4'hF, 1, 81, 3, 4'd9, 2, 1'b1);

    // Reset in the middle of WAIT
    req_valid_i = 4'hF;
    #1;
    chk("mw_grant", 32'(req_ready_o), 32'(4'h4));
    step();
    step();
    step();
    step();
    core_done_i = 1'b1;
    core_root_i = 4'h6;
    rst_n       = 1'b0;
    #1;
    chk_all_zero("mw_rst");
    step();
    step();
    chk_all_zero("mw_hold");
    core_done_i = 1'b0;
    rst_n       = 1'b1;
    #1;
    chk("mw_rel_ready", 32'(req_ready_o), 0);
    step();
    chk("mw_no_rsp",   32'(rsp_valid_o), 0);
    chk("mw_no_start", 32'(core_start_o), 0);
    job(4'hF, 0, 49, 2, 4'd7, 0, 1'b0);
    job(4'h4, 2, 100, 4, 4'd10, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
